// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the ALU: queues {op,A,B} commands, issues one at a time
// over the start/done handshake and returns result+status on a valid/ready response port.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [(1<<OP_W)-1:0] NOP_MASK = {{((1<<OP_W)-1){1'b0}}, 1'b1}
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [7:0]      cmd_a,
    input  logic [7:0]      cmd_b,
    output logic            alu_start,
    output logic [OP_W-1:0] alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    input  logic            alu_done,
    input  logic            alu_error,
    input  logic [15:0]     alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_result,
    output logic [1:0]      rsp_status,
    output logic            busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned ENT_W = OP_W + 16;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic [15:0]        result_q, result_d;
    logic [1:0]         status_q, status_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic               empty;
    logic               full;
    logic               push;
    logic [ENT_W-1:0]   head;
    logic [OP_W-1:0]    head_op;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push    = cmd_valid && !full;
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_op = head[ENT_W-1 -: OP_W];

    assign cmd_ready  = !full;
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_result = result_q;
    assign rsp_status = status_q;
    assign busy       = (state_q != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        status_d  = status_q;
        alu_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    {op_d, a_d, b_d} = head;
                    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
                    cnt_d    = '0;
                    if (NOP_MASK[head_op]) begin
                        result_d = '0;
                        status_d = ST_OK;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Start is a level until completion so the ALU never sees a second start.
                alu_start = !alu_done && !alu_error;
                if (alu_error) begin
                    result_d = '0;
                    status_d = ST_ILLEGAL;
                    state_d  = S_RESP;
                end else if (alu_done) begin
                    result_d = alu_result;
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small ALU model (add/sub/xor, op F illegal).
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic        alu_error;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_status;
    logic        busy;

    logic        hang;
    int          start_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    int          s0;

    alu_cmd_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_error  (alu_error),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ALU model: done one cycle after start unless hung; op F is illegal.
    always @(posedge clk) begin
        if (!reset_n) alu_done <= 1'b0;
        else          alu_done <= alu_start && !hang;
        if (alu_start) start_cnt <= start_cnt + 1;
    end

    assign alu_error = (alu_op == 4'hF);

    always_comb begin
        case (alu_op)
            4'h1:    alu_result = 16'(alu_a) + 16'(alu_b);
            4'h2:    alu_result = 16'(alu_a) - 16'(alu_b);
            4'h3:    alu_result = 16'(alu_a ^ alu_b);
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, check it, then step past its consumption.
    task automatic get_rsp(input string tag, input logic [15:0] res, input logic [1:0] st);
        int n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_result"}, 32'(rsp_result), 32'(res));
        chk({tag, "_status"}, 32'(rsp_status), 32'(st));
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        hang      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single ADD with exact cycle timing
        s0 = start_cnt;
        push(4'h1, 8'h12, 8'h34);
        chk("add_busy_idle", 32'(busy), 32'd1);
        chk("add_no_start_yet", 32'(alu_start), 32'd0);
        @(negedge clk);
        chk("add_start", 32'(alu_start), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'h1);
        chk("add_alu_a", 32'(alu_a), 32'h12);
        chk("add_alu_b", 32'(alu_b), 32'h34);
        @(negedge clk);
        chk("add_start_drop", 32'(alu_start), 32'd0);
        @(negedge clk);
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_result", 32'(rsp_result), 32'h0046);
        chk("add_rsp_status", 32'(rsp_status), 32'd0);
        @(negedge clk);
        chk("add_rsp_hold", 32'(rsp_result), 32'h0046);
        chk("add_start_count", 32'(start_cnt - s0), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("add_rsp_done", 32'(rsp_valid), 32'd0);
        chk("add_busy_done", 32'(busy), 32'd0);

        // Fill the FIFO while a response is held, then drain in order
        rsp_ready = 1'b0;
        push(4'h1, 8'h01, 8'h02);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        chk("fill_c0_valid", 32'(rsp_valid), 32'd1);
        chk("fill_ready1", 32'(cmd_ready), 32'd1);
        push(4'h2, 8'h10, 8'h03);
        chk("fill_ready2", 32'(cmd_ready), 32'd1);
        push(4'h3, 8'hF0, 8'h0F);
        chk("fill_ready3", 32'(cmd_ready), 32'd1);
        push(4'h1, 8'hFF, 8'hFF);
        chk("fill_ready4", 32'(cmd_ready), 32'd1);
        push(4'h1, 8'h80, 8'h01);
        chk("fill_ready5", 32'(cmd_ready), 32'd0);
        push(4'h1, 8'h00, 8'h01);
        chk("fill_c0_hold", 32'(rsp_result), 32'h0003);
        rsp_ready = 1'b1;
        get_rsp("fill_c0", 16'h0003, 2'b00);
        get_rsp("fill_c1", 16'h000D, 2'b00);
        get_rsp("fill_c2", 16'h00FF, 2'b00);
        get_rsp("fill_c3", 16'h01FE, 2'b00);
        get_rsp("fill_c4", 16'h0081, 2'b00);
        repeat (6) @(negedge clk);
        chk("fill_c5_dropped", 32'(rsp_valid), 32'd0);
        chk("fill_idle", 32'(busy), 32'd0);

        // Illegal opcode: never started
        s0 = start_cnt;
        push(4'hF, 8'h01, 8'h01);
        get_rsp("ill", 16'h0000, 2'b01);
        chk("ill_start_count", 32'(start_cnt - s0), 32'd0);

        // NOP opcode completes locally two cycles after push
        s0 = start_cnt;
        push(4'h0, 8'hAA, 8'h55);
        chk("nop_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("nop_valid", 32'(rsp_valid), 32'd1);
        chk("nop_result", 32'(rsp_result), 32'd0);
        chk("nop_status", 32'(rsp_status), 32'd0);
        chk("nop_start_count", 32'(start_cnt - s0), 32'd0);
        @(negedge clk);

        // Timeout: start held 16 cycles, then normal operation resumes
        hang = 1'b1;
        s0 = start_cnt;
        push(4'h1, 8'h05, 8'h06);
        get_rsp("tmo", 16'h0000, 2'b10);
        chk("tmo_start_count", 32'(start_cnt - s0), 32'd16);
        hang = 1'b0;
        s0 = start_cnt;
        push(4'h1, 8'h20, 8'h22);
        get_rsp("post_tmo", 16'h0042, 2'b00);
        chk("post_tmo_starts", 32'(start_cnt - s0), 32'd1);

        // Reset in WAIT with two commands queued
        hang = 1'b1;
        rsp_ready = 1'b0;
        push(4'h1, 8'h01, 8'h01);
        push(4'h2, 8'h02, 8'h01);
        push(4'h3, 8'h03, 8'h01);
        chk("rst_wait_start", 32'(alu_start), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstw_alu_start", 32'(alu_start), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
        reset_n = 1'b1;
        hang = 1'b0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || alu_start) seen = 1'b1;
        end
        chk("rstw_no_stale", 32'(seen), 32'd0);
        push(4'h2, 8'h09, 8'h04);
        get_rsp("rstw_after", 16'h0005, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
